// File: rtl/wb_arbiter_rvseed.sv
// Writeback arbiter and scoreboard for RVSEED: merges ALU, LSU and MDU results onto
// the single register-file write port and tracks destinations of outstanding long ops.
module wb_arbiter_rvseed #(
   parameter int unsigned CPU_WIDTH      = 32,
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned STARVE_LIMIT   = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      alu_wen,
   input  logic [REG_ADDR_WIDTH-1:0] alu_waddr,
   input  logic [CPU_WIDTH-1:0]      alu_wdata,
   input  logic                      lsu_valid,
   output logic                      lsu_ready,
   input  logic [REG_ADDR_WIDTH-1:0] lsu_waddr,
   input  logic [CPU_WIDTH-1:0]      lsu_wdata,
   input  logic                      mdu_valid,
   output logic                      mdu_ready,
   input  logic [REG_ADDR_WIDTH-1:0] mdu_waddr,
   input  logic [CPU_WIDTH-1:0]      mdu_wdata,
   input  logic                      iss_long_valid,
   input  logic [REG_ADDR_WIDTH-1:0] iss_long_waddr,
   input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
   input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
   input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
   output logic                      rs1_busy,
   output logic                      rs2_busy,
   output logic                      rd_busy,
   output logic                      wb_stall,
   output logic                      reg_wen,
   output logic [REG_ADDR_WIDTH-1:0] reg_waddr,
   output logic [CPU_WIDTH-1:0]      reg_wdata
);

   localparam int unsigned NUM_REGS = 1 << REG_ADDR_WIDTH;
   localparam int unsigned CNT_W    = 4;

   logic [NUM_REGS-1:0]       pending_q, pending_d;
   logic                      rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]          starve_cnt_q, starve_cnt_d;
   logic                      reg_wen_q, reg_wen_d;
   logic [REG_ADDR_WIDTH-1:0] reg_waddr_q, reg_waddr_d;
   logic [CPU_WIDTH-1:0]      reg_wdata_q, reg_wdata_d;
   logic                      out_long_q, out_long_d;

   logic                      stall;
   logic                      alu_req, lsu_req, mdu_req;
   logic                      grant_alu, grant_lsu, grant_mdu, grant_long;
   logic [REG_ADDR_WIDTH-1:0] win_addr;
   logic [CPU_WIDTH-1:0]      win_data;

   // Stall comes from the saturated counter, so the starved source is guaranteed the port.
   assign stall   = !rst && (starve_cnt_q == CNT_W'(STARVE_LIMIT));
   assign alu_req = alu_wen && (alu_waddr != '0) && !stall;
   assign lsu_req = lsu_valid && !rst;
   assign mdu_req = mdu_valid && !rst;

   // Single-winner grant: ALU first, then LSU/MDU round-robin.
   always_comb begin
      grant_alu = 1'b0;
      grant_lsu = 1'b0;
      grant_mdu = 1'b0;
      win_addr  = '0;
      win_data  = '0;
      if (alu_req) begin
         grant_alu = 1'b1;
      end else if (lsu_req && mdu_req) begin
         grant_lsu = !rr_ptr_q;
         grant_mdu = rr_ptr_q;
      end else begin
         grant_lsu = lsu_req;
         grant_mdu = mdu_req;
      end
      if (grant_alu) begin
         win_addr = alu_waddr;
         win_data = alu_wdata;
      end else if (grant_lsu) begin
         win_addr = lsu_waddr;
         win_data = lsu_wdata;
      end else if (grant_mdu) begin
         win_addr = mdu_waddr;
         win_data = mdu_wdata;
      end
   end

   assign grant_long = grant_lsu || grant_mdu;

   // Next-state for output register, round-robin pointer, starvation counter, scoreboard.
   always_comb begin
      reg_wen_d    = 1'b0;
      reg_waddr_d  = reg_waddr_q;
      reg_wdata_d  = reg_wdata_q;
      out_long_d   = grant_long;
      rr_ptr_d     = rr_ptr_q;
      starve_cnt_d = starve_cnt_q;
      pending_d    = pending_q;

      if ((grant_alu || grant_long) && (win_addr != '0)) begin
         reg_wen_d   = 1'b1;
         reg_waddr_d = win_addr;
         reg_wdata_d = win_data;
      end

      if (grant_long) begin
         rr_ptr_d = !rr_ptr_q;
      end

      if (grant_long || !(lsu_valid || mdu_valid)) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q != CNT_W'(STARVE_LIMIT)) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end

      // Clear first so a same-cycle re-issue to the same register wins.
      if (reg_wen_q && out_long_q) begin
         pending_d[reg_waddr_q] = 1'b0;
      end
      if (iss_long_valid && (iss_long_waddr != '0)) begin
         pending_d[iss_long_waddr] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q    <= '0;
         rr_ptr_q     <= 1'b0;
         starve_cnt_q <= '0;
         reg_wen_q    <= 1'b0;
         reg_waddr_q  <= '0;
         reg_wdata_q  <= '0;
         out_long_q   <= 1'b0;
      end else begin
         pending_q    <= pending_d;
         rr_ptr_q     <= rr_ptr_d;
         starve_cnt_q <= starve_cnt_d;
         reg_wen_q    <= reg_wen_d;
         reg_waddr_q  <= reg_waddr_d;
         reg_wdata_q  <= reg_wdata_d;
         out_long_q   <= out_long_d;
      end
   end

   assign lsu_ready = lsu_req && grant_lsu;
   assign mdu_ready = mdu_req && grant_mdu;
   assign wb_stall  = stall;
   assign reg_wen   = reg_wen_q;
   assign reg_waddr = reg_waddr_q;
   assign reg_wdata = reg_wdata_q;

   assign rs1_busy = (rs1_addr != '0) && pending_q[rs1_addr];
   assign rs2_busy = (rs2_addr != '0) && pending_q[rs2_addr];
   assign rd_busy  = (rd_addr  != '0) && pending_q[rd_addr];

endmodule
